mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative 32-bit multiply/divide unit with HI/LO result registers for the multi-cycle CPU. It sits beside the ALU in the execute stage and covers the mult/multu/div/divu/mfhi/mflo/mthi/mtlo instructions. The ALU cannot complete these in one combinational pass. The controller launches an operation with a one-cycle Start pulse, holds in its wait state while Busy is high, and reads Hi/Lo after Done.

## Interface
- No parameters; datapath width fixed at 32.
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- MDConf  input  2  operation: 00 mult (signed), 01 multu, 10 div (signed), 11 divu
- Start  input  1  launch request, sampled on rising edge
- In1  input  32  multiplicand / dividend
- In2  input  32  multiplier / divisor
- WriteHi  input  1  mthi: load Hi from WriteData
- WriteLo  input  1  mtlo: load Lo from WriteData
- WriteData  input  32  data for WriteHi/WriteLo
- Busy  output  1  operation in progress (CALC or FIX)
- Done  output  1  one-cycle pulse; Hi/Lo hold the new result
- Hi  output  32  HI register (product upper word / remainder)
- Lo  output  32  LO register (product lower word / quotient)

## Operation
- States: IDLE, CALC, FIX, DONE. Reset -> IDLE, Hi=Lo=0, Busy=0, Done=0, iteration counter=0.
- Start is accepted in IDLE or DONE. It latches MDConf, In1, In2 and goes to CALC with counter=0. In1/In2/MDConf may change afterwards without effect.
- Start in CALC or FIX is ignored. No queuing.
- Signed ops (mult, div): operands are converted to magnitudes. Result sign flags are latched at Start.
- Signed mult: product negated iff the operand signs differ.
- Signed div: quotient negated iff the signs differ. Remainder takes the sign of the dividend.
- Unsigned ops use the operands as-is.
- Multiply: radix-2 shift-add over a 64-bit accumulator, one multiplier bit per cycle, LSB first.
- Divide: restoring division, one quotient bit per cycle, MSB first. The 33-bit trial subtract uses partial remainder and divisor.
- CALC: one iteration per cycle. After 32 iterations (counter==31 at the edge) go to FIX.
- FIX: apply the sign correction and write Hi/Lo, then go to DONE.
- DONE: Done=1 for exactly one cycle, Busy=0, then go to IDLE. A Start sampled in DONE goes directly to CALC.
- Divide by zero:
  - No trap and no shortcut; it still takes the full latency.
  - Result for both div and divu: Lo=32'hFFFFFFFF, Hi=In1 as latched, unchanged.
- Signed overflow 0x80000000 / -1: Lo=0x80000000, Hi=0, from two's-complement wrap of the magnitude path.
- WriteHi/WriteLo:
  - Honoured only in IDLE or DONE; ignored while Busy.
  - Take effect at the next edge.
  - If asserted in the same cycle as an accepted Start, the write still lands; the completed operation later overwrites Hi/Lo.
- Hi/Lo are unchanged from FIX of one operation until the next FIX, an accepted WriteHi/WriteLo, or reset.

## Timing
- Let E0 be the edge that samples an accepted Start.
- Busy=1 in the cycles after E0 through the cycle after E32. CALC occupies edges E1..E32.
- Hi/Lo update at E33. Done=1 in the cycle after E33, so Done and the result are visible 33 cycles after E0.
- Earliest back-to-back Start is sampled at E34, while in DONE.
- Reset is synchronous and overrides everything, including mid-CALC. After the reset edge: IDLE, Busy=0, Done=0, Hi=Lo=0, and the partial result is discarded.
- Outputs are registered; no combinational path from the inputs to Busy, Done, Hi or Lo.

## Test plan
- multu, In1=In2=0xFFFFFFFF, Start at E0 -> Busy high for 33 cycles; at E33 Hi=0xFFFFFFFE, Lo=0x00000001; Done pulses exactly one cycle.
- mult -3 × 5, then back-to-back div -7 / 2 with Start sampled in DONE:
  - First result: Hi=0xFFFFFFFF, Lo=0xFFFFFFF1.
  - Second result: Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1).
- divu 7 / 0 -> Lo=0xFFFFFFFF, Hi=0x00000007 after 33 cycles.
- div 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0x00000000.
- Start a mult, then at cycle 5 pulse Start with other operands and assert WriteHi with 0x12345678 -> both ignored; the original result lands.
- Afterwards: WriteLo=0xA5A5A5A5 in IDLE -> Lo=0xA5A5A5A5 at the next edge.
- Reset asserted at cycle 10 of a divu -> next cycle Busy=0, Done=0, Hi=Lo=0.
- No Done pulse appears later. A fresh Start afterwards completes normally in 33 cycles.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Execute-stage handshake and data bundle between the controller and the
// iterative multiply/divide unit.
interface mult_div_unit_if;
    logic [1:0]  MDConf;
    logic        Start;
    logic [31:0] In1;
    logic [31:0] In2;
    logic        WriteHi;
    logic        WriteLo;
    logic [31:0] WriteData;
    logic        Busy;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;

    modport master (
        output MDConf, Start, In1, In2, WriteHi, WriteLo, WriteData,
        input  Busy, Done, Hi, Lo
    );

    modport slave (
        input  MDConf, Start, In1, In2, WriteHi, WriteLo, WriteData,
        output Busy, Done, Hi, Lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply (radix-2 shift-add) / divide (restoring) unit
// with HI/LO result registers; 33 cycles from accepted Start to Done.
module mult_div_unit (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state, state_next;
    logic [4:0]  count;
    logic        is_div;
    logic        neg_lo, neg_hi;
    logic [31:0] operand;
    logic [63:0] acc;
    logic [31:0] hi_q, lo_q;

    logic        start_ok;
    logic        signed_op, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum, div_shift, div_trial;
    logic [63:0] acc_step, prod_fixed;
    logic        busy, done;

    assign start_ok  = bus.Start && (state == IDLE || state == DONE);
    assign signed_op = ~bus.MDConf[0];
    assign a_neg     = signed_op & bus.In1[31];
    assign b_neg     = signed_op & bus.In2[31];
    assign a_mag     = a_neg ? (~bus.In1 + 32'd1) : bus.In1;
    assign b_mag     = b_neg ? (~bus.In2 + 32'd1) : bus.In2;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start_ok) state_next = CALC;
            CALC: begin
                busy = 1'b1;
                if (count == 5'd31) state_next = FIX;
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start_ok ? CALC : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, remaining dividend / quotient bits}.
    always_comb begin
        mul_sum    = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
        div_shift  = {acc[63:32], acc[31]};
        div_trial  = div_shift - {1'b0, operand};
        acc_step   = '0;
        if (is_div) begin
            if (!div_trial[32]) acc_step = {div_trial[31:0], acc[30:0], 1'b1};
            else                acc_step = {div_shift[31:0], acc[30:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc[31:1]};
        end
        prod_fixed = neg_lo ? (64'd0 - acc) : acc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            is_div  <= 1'b0;
            neg_lo  <= 1'b0;
            neg_hi  <= 1'b0;
            operand <= '0;
            acc     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        count  <= '0;
                        is_div <= bus.MDConf[1];
                        if (bus.MDConf[1]) begin
                            operand <= b_mag;
                            acc     <= {32'd0, a_mag};
                            // Zero divisor keeps the all-ones quotient unsigned.
                            neg_lo  <= (a_neg ^ b_neg) && (bus.In2 != 32'd0);
                            neg_hi  <= a_neg;
                        end else begin
                            operand <= a_mag;
                            acc     <= {32'd0, b_mag};
                            neg_lo  <= a_neg ^ b_neg;
                            neg_hi  <= a_neg ^ b_neg;
                        end
                    end
                    if (bus.WriteHi) hi_q <= bus.WriteData;
                    if (bus.WriteLo) lo_q <= bus.WriteData;
                end
                CALC: begin
                    acc   <= acc_step;
                    count <= count + 5'd1;
                end
                FIX: begin
                    if (is_div) begin
                        lo_q <= neg_lo ? (32'd0 - acc[31:0])  : acc[31:0];
                        hi_q <= neg_hi ? (32'd0 - acc[63:32]) : acc[63:32];
                    end else begin
                        lo_q <= prod_fixed[31:0];
                        hi_q <= prod_fixed[63:32];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Busy = busy;
    assign bus.Done = done;
    assign bus.Hi   = hi_q;
    assign bus.Lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: latency, signed/unsigned
// results, divide-by-zero, overflow, busy-time write/start masking, reset.
module tb_mult_div_unit;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    mult_div_unit_if bus ();

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operation; returns samples from E0 until Done (-1 on timeout)
    // and the number of samples with Busy high. Leaves time at the Done sample.
    task automatic do_op(input logic [1:0] conf, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_n);
        bus.MDConf = conf;
        bus.In1    = a;
        bus.In2    = b;
        bus.Start  = 1'b1;
        @(posedge clk); #1;
        bus.Start  = 1'b0;
        bus.MDConf = ~conf;
        bus.In1    = ~a;
        bus.In2    = ~b;
        lat    = -1;
        busy_n = 0;
        for (int k = 0; k <= 100; k++) begin
            if (bus.Done) begin
                lat = k;
                break;
            end
            if (bus.Busy) busy_n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.Busy); end
        checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.Done); end
        checks++; if (bus.Hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 00000000", bus.Hi); end
        checks++; if (bus.Lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 00000000", bus.Lo); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_multu_max;
        int lat, busy_n;
        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, busy_n);
        checks++; if (lat !== 33) begin errors++; $display("FAIL multu_latency: got %0d expected 33", lat); end
        checks++; if (busy_n !== 33) begin errors++; $display("FAIL multu_busy_cycles: got %0d expected 33", busy_n); end
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL multu_busy_at_done: got %b expected 0", bus.Busy); end
        checks++; if (bus.Hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi: got %h expected fffffffe", bus.Hi); end
        checks++; if (bus.Lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo: got %h expected 00000001", bus.Lo); end
        @(posedge clk); #1;
        checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse: got %b expected 0", bus.Done); end
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL multu_busy_after: got %b expected 0", bus.Busy); end
    endtask

    task automatic test_back_to_back;
        int lat, busy_n;
        do_op(2'b00, 32'hFFFFFFFD, 32'd5, lat, busy_n);
        checks++; if (lat !== 33) begin errors++; $display("FAIL mult_neg_latency: got %0d expected 33", lat); end
        checks++; if (bus.Hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_neg_hi: got %h expected ffffffff", bus.Hi); end
        checks++; if (bus.Lo !== 32'hFFFFFFF1) begin errors++; $display("FAIL mult_neg_lo: got %h expected fffffff1", bus.Lo); end
        // Start issued while Done is high: sampled in DONE.
        do_op(2'b10, 32'hFFFFFFF9, 32'd2, lat, busy_n);
        checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_div_latency: got %0d expected 33", lat); end
        checks++; if (busy_n !== 33) begin errors++; $display("FAIL b2b_div_busy_cycles: got %0d expected 33", busy_n); end
        checks++; if (bus.Lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL b2b_div_lo: got %h expected fffffffd", bus.Lo); end
        checks++; if (bus.Hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL b2b_div_hi: got %h expected ffffffff", bus.Hi); end
        @(posedge clk); #1;
    endtask

    task automatic test_div_by_zero;
        int lat, busy_n;
        do_op(2'b11, 32'd7, 32'd0, lat, busy_n);
        checks++; if (lat !== 33) begin errors++; $display("FAIL divu0_latency: got %0d expected 33", lat); end
        checks++; if (bus.Lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu0_lo: got %h expected ffffffff", bus.Lo); end
        checks++; if (bus.Hi !== 32'h00000007) begin errors++; $display("FAIL divu0_hi: got %h expected 00000007", bus.Hi); end
        @(posedge clk); #1;
        do_op(2'b10, 32'hFFFFFFFB, 32'd0, lat, busy_n);
        checks++; if (lat !== 33) begin errors++; $display("FAIL div0_latency: got %0d expected 33", lat); end
        checks++; if (bus.Lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL div0_lo: got %h expected ffffffff", bus.Lo); end
        checks++; if (bus.Hi !== 32'hFFFFFFFB) begin errors++; $display("FAIL div0_hi: got %h expected fffffffb", bus.Hi); end
        @(posedge clk); #1;
    endtask

    task automatic test_div_overflow;
        int lat, busy_n;
        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, lat, busy_n);
        checks++; if (lat !== 33) begin errors++; $display("FAIL ovf_latency: got %0d expected 33", lat); end
        checks++; if (bus.Lo !== 32'h80000000) begin errors++; $display("FAIL ovf_lo: got %h expected 80000000", bus.Lo); end
        checks++; if (bus.Hi !== 32'h00000000) begin errors++; $display("FAIL ovf_hi: got %h expected 00000000", bus.Hi); end
        @(posedge clk); #1;
        do_op(2'b11, 32'd100, 32'd7, lat, busy_n);
        checks++; if (bus.Lo !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h expected 0000000e", bus.Lo); end
        checks++; if (bus.Hi !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h expected 00000002", bus.Hi); end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_while_busy;
        int lat;
        bus.MDConf = 2'b00;
        bus.In1    = 32'd6;
        bus.In2    = 32'd7;
        bus.Start  = 1'b1;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        lat = -1;
        for (int k = 0; k <= 100; k++) begin
            if (bus.Done) begin
                lat = k;
                break;
            end
            if (k == 4) begin
                bus.Start     = 1'b1;
                bus.MDConf    = 2'b11;
                bus.In1       = 32'd100;
                bus.In2       = 32'd3;
                bus.WriteHi   = 1'b1;
                bus.WriteData = 32'h12345678;
            end else begin
                bus.Start   = 1'b0;
                bus.WriteHi = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.Start   = 1'b0;
        bus.WriteHi = 1'b0;
        checks++; if (lat !== 33) begin errors++; $display("FAIL busy_ignore_latency: got %0d expected 33", lat); end
        checks++; if (bus.Hi !== 32'd0) begin errors++; $display("FAIL busy_ignore_hi: got %h expected 00000000", bus.Hi); end
        checks++; if (bus.Lo !== 32'd42) begin errors++; $display("FAIL busy_ignore_lo: got %h expected 0000002a", bus.Lo); end
        @(posedge clk); #1;
        checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL busy_ignore_no_requeue: got %b expected 0", bus.Done); end
    endtask

    task automatic test_write_lo;
        bus.WriteLo   = 1'b1;
        bus.WriteData = 32'hA5A5A5A5;
        @(posedge clk); #1;
        bus.WriteLo = 1'b0;
        checks++; if (bus.Lo !== 32'hA5A5A5A5) begin errors++; $display("FAIL mtlo_lo: got %h expected a5a5a5a5", bus.Lo); end
        checks++; if (bus.Hi !== 32'd0) begin errors++; $display("FAIL mtlo_hi_kept: got %h expected 00000000", bus.Hi); end
    endtask

    task automatic test_reset_mid_op;
        int lat, busy_n, done_seen;
        bus.MDConf = 2'b11;
        bus.In1    = 32'd100;
        bus.In2    = 32'd7;
        bus.Start  = 1'b1;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        checks++; if (bus.Busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", bus.Busy); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus.Busy); end
        checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", bus.Done); end
        checks++; if (bus.Hi !== 32'd0) begin errors++; $display("FAIL midrst_hi: got %h expected 00000000", bus.Hi); end
        checks++; if (bus.Lo !== 32'd0) begin errors++; $display("FAIL midrst_lo: got %h expected 00000000", bus.Lo); end
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.Done || bus.Busy) done_seen++;
            @(posedge clk); #1;
        end
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL midrst_stale_activity: got %0d expected 0", done_seen); end
        do_op(2'b11, 32'd100, 32'd7, lat, busy_n);
        checks++; if (lat !== 33) begin errors++; $display("FAIL midrst_fresh_latency: got %0d expected 33", lat); end
        checks++; if (bus.Lo !== 32'd14) begin errors++; $display("FAIL midrst_fresh_lo: got %h expected 0000000e", bus.Lo); end
        checks++; if (bus.Hi !== 32'd2) begin errors++; $display("FAIL midrst_fresh_hi: got %h expected 00000002", bus.Hi); end
        @(posedge clk); #1;
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        reset         = 1'b1;
        bus.MDConf    = 2'b00;
        bus.Start     = 1'b0;
        bus.In1       = '0;
        bus.In2       = '0;
        bus.WriteHi   = 1'b0;
        bus.WriteLo   = 1'b0;
        bus.WriteData = '0;
        test_reset();
        test_multu_max();
        test_back_to_back();
        test_div_by_zero();
        test_div_overflow();
        test_ignore_while_busy();
        test_write_lo();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
